// File: rtl/uart_in_rx_if.sv
// Serial input and decoded-result bundle for the hex UART receiver.
// slave: the receiver side; master: whatever drives the line and consumes results.
interface uart_in_rx_if;
  logic       uart_rx;
  logic [3:0] in_nib;
  logic       nib_valid;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       non_hex;
  logic       frame_err;
  logic       rx_busy;

  modport slave (
    input  uart_rx,
    output in_nib, nib_valid, rx_byte, byte_valid, non_hex, frame_err, rx_busy
  );

  modport master (
    output uart_rx,
    input  in_nib, nib_valid, rx_byte, byte_valid, non_hex, frame_err, rx_busy
  );
endinterface

// File: rtl/uart_in_rx.sv
// 8N1 UART receiver that decodes ASCII hex characters into a held 4-bit nibble
// for the CPU `in` port, with raw byte and per-frame status pulses.
module uart_in_rx #(
  parameter int unsigned CLK_HZ = 12_000_000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic         clk,
  input  logic         nrst,
  uart_in_rx_if.slave  bus
);

  localparam int unsigned DIV   = CLK_HZ / BAUD;
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t           r_state, w_state_nx;
  logic [1:0]       r_sync;
  logic             r_rxs_d;
  logic [2:0]       r_live;
  logic             w_rxs, w_fall;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [2:0]       r_bit, w_bit_nx;
  logic [7:0]       r_shift, w_shift_nx;
  logic [7:0]       r_rx_byte, w_rx_byte_nx;
  logic [3:0]       r_in_nib, w_in_nib_nx;
  logic             r_byte_valid, w_byte_valid_nx;
  logic             r_nib_valid, w_nib_valid_nx;
  logic             r_non_hex, w_non_hex_nx;
  logic             r_frame_err, w_frame_err_nx;
  logic             r_busy;
  logic             w_is_hex;
  logic [3:0]       w_nib;

  assign w_rxs = r_sync[1];
  // r_live masks the preset-high synchronizer so a line held low out of reset is not an edge
  assign w_fall = r_live[2] & r_rxs_d & ~w_rxs;

  // Input synchronizer and edge-detect history
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sync  <= 2'b11;
      r_rxs_d <= 1'b1;
      r_live  <= 3'b000;
    end else begin
      r_sync  <= {r_sync[0], bus.uart_rx};
      r_rxs_d <= w_rxs;
      r_live  <= {r_live[1:0], 1'b1};
    end
  end

  // ASCII hex decode of the assembled byte
  always_comb begin
    w_is_hex = 1'b0;
    w_nib    = r_shift[3:0];
    if (r_shift >= 8'h30 && r_shift <= 8'h39) begin
      w_is_hex = 1'b1;
    end else if ((r_shift >= 8'h41 && r_shift <= 8'h46) ||
                 (r_shift >= 8'h61 && r_shift <= 8'h66)) begin
      w_is_hex = 1'b1;
      w_nib    = r_shift[3:0] + 4'd9;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nx      = r_state;
    w_cnt_nx        = r_cnt;
    w_bit_nx        = r_bit;
    w_shift_nx      = r_shift;
    w_rx_byte_nx    = r_rx_byte;
    w_in_nib_nx     = r_in_nib;
    w_byte_valid_nx = 1'b0;
    w_nib_valid_nx  = 1'b0;
    w_non_hex_nx    = 1'b0;
    w_frame_err_nx  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_nx = S_START;
          w_cnt_nx   = '0;
        end
      end
      S_START: begin
        if (r_cnt == CNT_W'(HALF - 1)) begin
          w_cnt_nx = '0;
          if (!w_rxs) begin
            w_state_nx = S_DATA;
            w_bit_nx   = 3'd0;
          end else begin
            w_state_nx = S_IDLE;
          end
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (r_cnt == CNT_W'(DIV - 1)) begin
          w_cnt_nx   = '0;
          w_shift_nx = {w_rxs, r_shift[7:1]};
          w_bit_nx   = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_state_nx = S_STOP;
          end
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (r_cnt == CNT_W'(DIV - 1)) begin
          w_cnt_nx = '0;
          if (w_rxs) begin
            w_state_nx      = S_IDLE;
            w_rx_byte_nx    = r_shift;
            w_byte_valid_nx = 1'b1;
            if (w_is_hex) begin
              w_in_nib_nx    = w_nib;
              w_nib_valid_nx = 1'b1;
            end else begin
              w_non_hex_nx = 1'b1;
            end
          end else begin
            w_state_nx     = S_WAIT_HIGH;
            w_frame_err_nx = 1'b1;
          end
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      S_WAIT_HIGH: begin
        // Hold off on a break so a long low line cannot retrigger frames
        if (w_rxs) begin
          w_state_nx = S_IDLE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit        <= 3'd0;
      r_shift      <= 8'h00;
      r_rx_byte    <= 8'h00;
      r_in_nib     <= 4'h0;
      r_byte_valid <= 1'b0;
      r_nib_valid  <= 1'b0;
      r_non_hex    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_bit        <= w_bit_nx;
      r_shift      <= w_shift_nx;
      r_rx_byte    <= w_rx_byte_nx;
      r_in_nib     <= w_in_nib_nx;
      r_byte_valid <= w_byte_valid_nx;
      r_nib_valid  <= w_nib_valid_nx;
      r_non_hex    <= w_non_hex_nx;
      r_frame_err  <= w_frame_err_nx;
      r_busy       <= (w_state_nx != S_IDLE);
    end
  end

  assign bus.in_nib     = r_in_nib;
  assign bus.nib_valid  = r_nib_valid;
  assign bus.rx_byte    = r_rx_byte;
  assign bus.byte_valid = r_byte_valid;
  assign bus.non_hex    = r_non_hex;
  assign bus.frame_err  = r_frame_err;
  assign bus.rx_busy    = r_busy;

endmodule

// File: tb/tb_uart_in_rx.sv
// Bench for uart_in_rx: table-driven frames plus hand sequences for glitch,
// framing error and mid-frame reset; expected results go through a scoreboard queue.
module tb_uart_in_rx;

  localparam int DIV = 12_000_000 / 115200;

  typedef struct {
    logic [7:0] b;
    logic       nv;
    logic [3:0] nib;
    logic       nh;
  } vec_t;

  typedef struct {
    logic       good;
    logic [7:0] rx_byte;
    logic       nib_valid;
    logic [3:0] in_nib;
    logic       non_hex;
  } exp_t;

  logic clk;
  logic nrst;
  int   total;
  int   bad;
  int   cyc;
  exp_t sb[$];
  int   stamps[$];
  logic [3:0] prev_nib;
  vec_t tbl[16];

  uart_in_rx_if bus();

  uart_in_rx dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard consumer and continuous pulse/stability checks
  always @(negedge clk) begin
    exp_t e;
    if (nrst) begin
      if (bus.byte_valid || bus.frame_err) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: byte_valid=%0b frame_err=%0b rx_byte=%0h",
                   bus.byte_valid, bus.frame_err, bus.rx_byte);
        end else begin
          e = sb.pop_front();
          check("byte_valid", 8'(bus.byte_valid), 8'(e.good));
          check("frame_err", 8'(bus.frame_err), 8'(!e.good));
          check("rx_byte", bus.rx_byte, e.rx_byte);
          check("nib_valid", 8'(bus.nib_valid), 8'(e.nib_valid));
          check("in_nib", 8'(bus.in_nib), 8'(e.in_nib));
          check("non_hex", 8'(bus.non_hex), 8'(e.non_hex));
        end
      end else if (bus.nib_valid || bus.non_hex) begin
        total++;
        bad++;
        $display("FAIL orphan_pulse: nib_valid=%0b non_hex=%0b", bus.nib_valid, bus.non_hex);
      end
      if (bus.nib_valid) stamps.push_back(cyc);
      if (!bus.nib_valid) check("in_nib_stable", 8'(bus.in_nib), 8'(prev_nib));
    end
    prev_nib = bus.in_nib;
  end

  task automatic drive_bit(input logic v, input int n);
    bus.uart_rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    drive_bit(1'b0, DIV);
    for (int i = 0; i < 8; i++) drive_bit(b[i], DIV);
    drive_bit(1'b1, DIV);
  endtask

  task automatic push_good(input logic [7:0] b, input logic nv, input logic [3:0] nib, input logic nh);
    exp_t e;
    e.good = 1'b1; e.rx_byte = b; e.nib_valid = nv; e.in_nib = nib; e.non_hex = nh;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: pending=%0d want 0", name, sb.size());
      sb.delete();
    end
    @(negedge clk);
    check({name, "_busy_idle"}, 8'(bus.rx_busy), 8'h00);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; prev_nib = 4'h0;
    tbl[0]  = '{8'h61, 1'b1, 4'hA, 1'b0};
    tbl[1]  = '{8'h46, 1'b1, 4'hF, 1'b0};
    tbl[2]  = '{8'h35, 1'b1, 4'h5, 1'b0};
    tbl[3]  = '{8'h37, 1'b1, 4'h7, 1'b0};
    tbl[4]  = '{8'h47, 1'b0, 4'h7, 1'b1};
    tbl[5]  = '{8'h30, 1'b1, 4'h0, 1'b0};
    tbl[6]  = '{8'h40, 1'b0, 4'h0, 1'b1};
    tbl[7]  = '{8'h39, 1'b1, 4'h9, 1'b0};
    tbl[8]  = '{8'h3A, 1'b0, 4'h9, 1'b1};
    tbl[9]  = '{8'h66, 1'b1, 4'hF, 1'b0};
    tbl[10] = '{8'h60, 1'b0, 4'hF, 1'b1};
    tbl[11] = '{8'h67, 1'b0, 4'hF, 1'b1};
    tbl[12] = '{8'h41, 1'b1, 4'hA, 1'b0};
    tbl[13] = '{8'h2F, 1'b0, 4'hA, 1'b1};
    tbl[14] = '{8'hFF, 1'b0, 4'hA, 1'b1};
    tbl[15] = '{8'h00, 1'b0, 4'hA, 1'b1};

    // Reset with the line held low: no frame may start when it is released
    bus.uart_rx = 1'b0;
    nrst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_in_nib", 8'(bus.in_nib), 8'h00);
    check("rst_rx_byte", bus.rx_byte, 8'h00);
    check("rst_busy", 8'(bus.rx_busy), 8'h00);
    check("rst_pulses", 8'({bus.byte_valid, bus.nib_valid, bus.non_hex, bus.frame_err}), 8'h00);
    nrst = 1'b1;
    repeat (20) @(negedge clk);
    check("low_at_reset_busy", 8'(bus.rx_busy), 8'h00);
    bus.uart_rx = 1'b1;
    repeat (20) @(negedge clk);

    // Table: back-to-back frames with a single stop bit
    for (int i = 0; i < 16; i++) begin
      push_good(tbl[i].b, tbl[i].nv, tbl[i].nib, tbl[i].nh);
      send_byte(tbl[i].b);
    end
    wait_drain("table");
    if (stamps.size() >= 2) check("nib_spacing", 8'((stamps[1] - stamps[0]) / 8), 8'((10 * DIV) / 8));
    else check("nib_stamps", 8'(stamps.size()), 8'd2);

    // Short low glitch is rejected in START
    drive_bit(1'b0, 20);
    drive_bit(1'b1, 200);
    check("glitch_busy", 8'(bus.rx_busy), 8'h00);
    check("glitch_in_nib", 8'(bus.in_nib), 8'h0A);
    push_good(8'h33, 1'b1, 4'h3, 1'b0);
    send_byte(8'h33);
    wait_drain("after_glitch");

    // Stop bit held low for three bit times
    begin
      exp_t e;
      e.good = 1'b0; e.rx_byte = 8'h33; e.nib_valid = 1'b0; e.in_nib = 4'h3; e.non_hex = 1'b0;
      sb.push_back(e);
    end
    drive_bit(1'b0, DIV);
    for (int i = 0; i < 8; i++) drive_bit(bus.uart_rx ^ bus.uart_rx ^ ((8'h39 >> i) & 8'h01) != 0, DIV);
    drive_bit(1'b0, 2 * DIV);
    check("ferr_busy_low", 8'(bus.rx_busy), 8'h01);
    check("ferr_pending", 8'(sb.size()), 8'h00);
    drive_bit(1'b0, DIV);
    check("ferr_busy_still", 8'(bus.rx_busy), 8'h01);
    drive_bit(1'b1, 20);
    check("ferr_busy_release", 8'(bus.rx_busy), 8'h00);
    push_good(8'h31, 1'b1, 4'h1, 1'b0);
    send_byte(8'h31);
    wait_drain("after_ferr");

    // Reset in the middle of a data field
    push_good(8'h32, 1'b1, 4'h2, 1'b0);
    send_byte(8'h32);
    wait_drain("pre_reset");
    drive_bit(1'b0, DIV);
    drive_bit(1'b1, DIV);
    drive_bit(1'b0, DIV);
    drive_bit(1'b0, DIV / 2);
    nrst = 1'b0;
    bus.uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_in_nib", 8'(bus.in_nib), 8'h00);
    check("midrst_rx_byte", bus.rx_byte, 8'h00);
    check("midrst_busy", 8'(bus.rx_busy), 8'h00);
    check("midrst_pulses", 8'({bus.byte_valid, bus.nib_valid, bus.non_hex, bus.frame_err}), 8'h00);
    nrst = 1'b1;
    repeat (2 * DIV * 10) @(negedge clk);
    check("post_rst_busy", 8'(bus.rx_busy), 8'h00);
    push_good(8'h38, 1'b1, 4'h8, 1'b0);
    send_byte(8'h38);
    wait_drain("after_reset");
    check("final_in_nib", 8'(bus.in_nib), 8'h08);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_in_rx.md
Name: uart_in_rx

Overview:
- UART receiver (8N1) that acts as the return path to the CPU's 4-bit `in` port.
- Receives ASCII hex characters from a host and decodes '0'-'9', 'A'-'F' and 'a'-'f' into a 4-bit nibble.
- Holds the last valid nibble stably so it can drive the ALU `in` input directly.
- Also exposes the raw received byte and per-frame status pulses for debug LEDs and for the host echo path.

Parameters:
- CLK_HZ, 12_000_000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate. DIV = CLK_HZ/BAUD, integer truncation (104 at defaults). HALF = DIV/2 (52).

Ports:
- clk  in  1  system clock, 12MHz.
- nrst  in  1  asynchronous reset, active low.
- uart_rx  in  1  raw serial input, idle high, asynchronous to clk.
- in_nib  out  4  last successfully decoded hex nibble; drives the CPU `in` port.
- nib_valid  out  1  one-clk pulse when in_nib is updated.
- rx_byte  out  8  last byte received with a good stop bit.
- byte_valid  out  1  one-clk pulse when rx_byte is updated.
- non_hex  out  1  one-clk pulse: good frame, but the byte is not a hex character.
- frame_err  out  1  one-clk pulse: stop bit sampled low.
- rx_busy  out  1  high while in any state other than IDLE.

Behaviour:
- Reset: one clock domain (clk); reset is asynchronous and active-low (nrst). While nrst=0: in_nib=0, rx_byte=0, all pulse outputs=0, rx_busy=0, synchronizer flops=1, state=IDLE, counters=0. Reset mid-frame abandons the frame; nothing is reported.
- Input sync: uart_rx passes through a 2-flop synchronizer that resets to 1; call its output rxs. All decisions use rxs only.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - On rxs falling edge (previous rxs=1, current rxs=0): go to START, baud counter=0.
  - A line that is already low when leaving reset does not start a frame.
- START: count HALF clocks, then sample rxs.
  - rxs=0: go to DATA with bit index=0 and counter=0.
  - rxs=1 (glitch/false start): go to IDLE; no outputs pulse.
- DATA: every DIV clocks, sample rxs into the shift register, LSB first. After the 8th sample, go to STOP.
- STOP: after DIV clocks, sample rxs.
  - rxs=1: go to IDLE.
  - rxs=0: pulse frame_err and go to WAIT_HIGH; rx_byte and in_nib are unchanged.
- WAIT_HIGH: stay until rxs=1, then go to IDLE. This prevents a break condition from retriggering frames.
- Good frame outputs: registered, asserted in the clk following the stop sample.
  - Always: rx_byte is loaded and byte_valid pulses.
  - Byte in 0x30-0x39: in_nib = byte-0x30.
  - Byte in 0x41-0x46 or 0x61-0x66: in_nib = (byte&0x0F)+9.
  - In either hex case, nib_valid pulses in the same clk as byte_valid.
  - Any other byte: non_hex pulses, in_nib holds, nib_valid stays 0.
- Pulse exclusivity: nib_valid and non_hex are mutually exclusive. frame_err never coincides with byte_valid.
- Frame timing: a frame completes at roughly 9.5*DIV clocks after the synced falling edge. The next start edge is accepted in the first IDLE clk after the stop sample, so back-to-back frames are supported with no gap beyond one stop bit.
- Stability: in_nib changes only on nib_valid. It is glitch-free and stable between updates, so the CPU may sample it at any cycle.
- Width rules: the baud counter is wide enough for DIV-1 (7 bits at defaults) and wraps to 0 at each sample. The bit index is 3 bits.

Test Plan:
- Send 0x35 ('5') at 104 clk/bit -> byte_valid and nib_valid pulse together once, rx_byte=0x35, in_nib=4'h5, non_hex=0, frame_err=0, rx_busy back to 0.
- Send 'a' (0x61), then 'F' (0x46) back-to-back with one stop bit -> in_nib=4'hA then 4'hF, two nib_valid pulses about 1040 clks apart.
- Send 'G' (0x47) after '7' -> byte_valid and non_hex pulse, rx_byte=0x47, in_nib stays 4'h7, no nib_valid.
- Drive a 20-clk low glitch on uart_rx -> START rejects it, no output pulses, state IDLE. Then send '3' -> in_nib=4'h3.
- Send 0x39 with the stop bit held low for 3 bit times -> frame_err pulses exactly once, no byte_valid, rx_busy stays high until the line returns high, then the next '1' decodes to in_nib=4'h1.
- Assert nrst low mid-DATA of '9' after '2' -> in_nib=0, rx_byte=0, no pulses. After release with the line idle high, send '8' -> in_nib=4'h8.
